spike_pushback_fifo: RTL and testbench
======================================

# spike_pushback_fifo

Buffered, parametrised spike pushback unit for the tinyODIN neuromorphic core. It captures output-layer spike events from the core's time-multiplexed neuron scan and queues their addresses in a first-word-fall-through FIFO, which the host drains through a valid/ready pop port. It also runs a small inference state machine that detects end-of-inference, either on the first spike from a class neuron or on a tick timeout, and latches the winning neuron address.

## Interface

Parameters
- `M`, 8: neuron address width; `count_i`, `pop_addr_o` and `winner_addr_o` are `M` bits wide.
- `INPUT_RESO`, 8: tick counter width.
- `DEPTH`, 8: FIFO entries; a power of 2, at least 2.
- `CLASS_BASE`, 246: lowest class-neuron address. Addresses `>= CLASS_BASE` are output classes.
- `TICK_END`, 1: `tick_i` value that ends inference by timeout.

Ports
- `clk_i`  in  1  clock. Single clock domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle pulse; clears the FIFO and flags and starts an inference.
- `spike_i`  in  1  spike event from the neuron scan.
- `count_i`  in  M  address of the neuron currently scanned.
- `tick_i`  in  INPUT_RESO  current input tick.
- `pop_valid_o`  out  1  FIFO head is valid.
- `pop_addr_o`  out  M  FIFO head address.
- `pop_ready_i`  in  1  consumer accepts the head.
- `level_o`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow_o`  out  1  sticky: a push was dropped because the FIFO was full.
- `done_o`  out  1  inference finished; level signal.
- `winner_valid_o`  out  1  inference ended on a class spike.
- `winner_addr_o`  out  M  address of the winning class neuron.
- `timeout_o`  out  1  inference ended on `TICK_END`.

## Operation

- FSM states: `IDLE`, `RUN`, `DONE`. Reset state is `IDLE`.
- `start_i` in any state:
  - clears the FIFO, `overflow_o`, `winner_valid_o`, `winner_addr_o` and `timeout_o`;
  - moves the FSM to `RUN`.
- `RUN`:
  - Each cycle with `spike_i=1` pushes `count_i`.
  - If `spike_i && count_i >= CLASS_BASE`: latch `winner_addr_o` from `count_i`, set `winner_valid_o`, go to `DONE`. The spike itself is also pushed.
  - Else if `tick_i == TICK_END`: set `timeout_o`, go to `DONE`.
  - If both conditions hold in the same cycle, the spike wins: `winner_valid_o=1`, `timeout_o=0`.
- `DONE`:
  - `done_o=1`.
  - Spikes are ignored: no push, no overflow.
  - Remains in `DONE` until `start_i`.
- `IDLE`: spikes are ignored.
- FIFO:
  - Read and write pointers are `$clog2(DEPTH)+1` bits with wrap bit. Full when indices are equal and wrap bits differ; empty when pointers are equal.
  - A push when full with no pop in the same cycle is dropped and sets `overflow_o`.
  - Full plus simultaneous pop and push: both are accepted and the level is unchanged.
  - Empty plus push: `pop_ready_i` has no effect that cycle.
- Pop occurs when `pop_valid_o && pop_ready_i`. `pop_addr_o` holds its value while `pop_valid_o=1` and `pop_ready_i=0`.
- `start_i` coinciding with a push or pop: `start_i` takes priority, and the FIFO is empty the next cycle.

## Timing

- Reset values:
  - `pop_valid_o=0`, `pop_addr_o=0`, `level_o=0`;
  - `overflow_o=0`, `done_o=0`, `winner_valid_o=0`, `winner_addr_o=0`, `timeout_o=0`.
- Push latency is 1: a spike at cycle N gives `pop_valid_o=1` with that address at N+1 when the FIFO was empty.
- `level_o` updates the cycle after a push or pop.
- `done_o`, `winner_*` and `timeout_o` assert one cycle after the ending condition.
- `start_i` at N: the FSM is in `RUN` with all flags cleared at N+1. A spike at N is discarded; a spike at N+1 is captured.
- Reset asserted mid-inference: all state clears asynchronously and the FSM enters `IDLE`.

## Configuration

- Macro `SPIKE_PUSHBACK_DROP_CNT_EN`.
- Defined: adds output `drop_cnt_o [15:0]`.
  - Increments on every dropped push and saturates at 16'hFFFF.
  - Cleared by reset and by `start_i`.
- Undefined: the port and counter are absent.
- All other behaviour is identical in both builds.

## Test plan

- Reset, then `start_i`; spikes at addresses 3, 17, 40 on consecutive cycles with `pop_ready_i=0` → `level_o`=3; then raise `pop_ready_i` → pops return 3, 17, 40 in order, then `pop_valid_o=0`.
- `DEPTH`=8; 10 spikes at addresses 0..9 with no pop → `level_o`=8, `overflow_o=1`, FIFO holds 0..7 (`drop_cnt_o`=2 when the macro is enabled).
- FIFO full, then simultaneous push of 100 and pop → the popped value is the oldest entry, 100 is enqueued, `level_o` stays 8, `overflow_o` unchanged.
- In `RUN`, spike at 250 → next cycle `done_o=1`, `winner_valid_o=1`, `winner_addr_o`=250, 250 is in the FIFO; a later spike at 12 is not pushed.
- Spike at 248 in the same cycle as `tick_i`=1 → `winner_valid_o=1`, `timeout_o=0`. Separate run with no class spike and `tick_i`=1 → `timeout_o=1`, `winner_valid_o=0`.
- Reset asserted while in `RUN` with 4 entries → all outputs 0 and FSM in `IDLE`; a spike without `start_i` is not pushed.

Source files
------------

// File: rtl/spike_pushback_fifo.sv
// Spike pushback unit: queues output-layer spike addresses in a FWFT FIFO
// drained by a valid/ready pop port, and runs the IDLE/RUN/DONE inference FSM
// that latches the winning class neuron or flags a tick timeout.
// Optional build macro SPIKE_PUSHBACK_DROP_CNT_EN adds a saturating drop counter.
module spike_pushback_fifo #(
  parameter int unsigned M          = 8,
  parameter int unsigned INPUT_RESO = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CLASS_BASE = 246,
  parameter int unsigned TICK_END   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         spike_i,
  input  logic [M-1:0]                 count_i,
  input  logic [INPUT_RESO-1:0]        tick_i,
  output logic                         pop_valid_o,
  output logic [M-1:0]                 pop_addr_o,
  input  logic                         pop_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         overflow_o,
  output logic                         done_o,
  output logic                         winner_valid_o,
  output logic [M-1:0]                 winner_addr_o,
  output logic                         timeout_o
`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  localparam logic [M-1:0]          ClassBase = M'(CLASS_BASE);
  localparam logic [INPUT_RESO-1:0] TickEnd   = INPUT_RESO'(TICK_END);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            winner_valid_q, winner_valid_d;
  logic [M-1:0]    winner_addr_q, winner_addr_d;
  logic            timeout_q, timeout_d;
  logic [M-1:0]    mem_q [DEPTH];

  logic            full, empty;
  logic            push_req, push_fire, pop_fire, drop;
  logic            class_hit;
  logic [PW-1:0]   occupancy;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // start_i wins over any FIFO traffic in its cycle
  assign push_req  = (state_q == StRun) && spike_i && !start_i;
  assign pop_fire  = !empty && pop_ready_i && !start_i;
  assign push_fire = push_req && (!full || pop_fire);
  assign drop      = push_req && full && !pop_fire;
  assign class_hit = spike_i && (count_i >= ClassBase);

  // Next-state: FSM, pointers and sticky flags
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    overflow_d     = overflow_q;
    winner_valid_d = winner_valid_q;
    winner_addr_d  = winner_addr_q;
    timeout_d      = timeout_q;
    if (start_i) begin
      state_d        = StRun;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      overflow_d     = 1'b0;
      winner_valid_d = 1'b0;
      winner_addr_d  = '0;
      timeout_d      = 1'b0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (drop)      overflow_d = 1'b1;
      unique case (state_q)
        StRun: begin
          // A class spike beats a simultaneous timeout
          if (class_hit) begin
            winner_valid_d = 1'b1;
            winner_addr_d  = count_i;
            state_d        = StDone;
          end else if (tick_i == TickEnd) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      winner_valid_q <= 1'b0;
      winner_addr_q  <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      overflow_q     <= overflow_d;
      winner_valid_q <= winner_valid_d;
      winner_addr_q  <= winner_addr_d;
      timeout_q      <= timeout_d;
    end
  end

  // FIFO storage; contents are masked at the output while empty, so no reset
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q[AW-1:0]] <= count_i;
  end

`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped pushes
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (start_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign occupancy      = wr_ptr_q - rd_ptr_q;
  assign level_o        = LW'(occupancy);
  assign pop_valid_o    = !empty;
  assign pop_addr_o     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o     = overflow_q;
  assign done_o         = (state_q == StDone);
  assign winner_valid_o = winner_valid_q;
  assign winner_addr_o  = winner_addr_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_spike_pushback_fifo.sv
// Directed self-checking bench for spike_pushback_fifo (default parameters).
module tb_spike_pushback_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        spike_i;
  logic [7:0]  count_i;
  logic [7:0]  tick_i;
  logic        pop_valid_o;
  logic [7:0]  pop_addr_o;
  logic        pop_ready_i;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic        done_o;
  logic        winner_valid_o;
  logic [7:0]  winner_addr_o;
  logic        timeout_o;
`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  spike_pushback_fifo dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .spike_i        (spike_i),
    .count_i        (count_i),
    .tick_i         (tick_i),
    .pop_valid_o    (pop_valid_o),
    .pop_addr_o     (pop_addr_o),
    .pop_ready_i    (pop_ready_i),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .done_o         (done_o),
    .winner_valid_o (winner_valid_o),
    .winner_addr_o  (winner_addr_o),
    .timeout_o      (timeout_o)
`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
    ,
    .drop_cnt_o     (drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pop_valid"}, 32'(pop_valid_o), 32'd0);
    check({tag, " pop_addr"}, 32'(pop_addr_o), 32'd0);
    check({tag, " level"}, 32'(level_o), 32'd0);
    check({tag, " overflow"}, 32'(overflow_o), 32'd0);
    check({tag, " done"}, 32'(done_o), 32'd0);
    check({tag, " winner_valid"}, 32'(winner_valid_o), 32'd0);
    check({tag, " winner_addr"}, 32'(winner_addr_o), 32'd0);
    check({tag, " timeout"}, 32'(timeout_o), 32'd0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic spike(input logic [7:0] addr);
    spike_i = 1'b1;
    count_i = addr;
    step();
    spike_i = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [$];
    rst_i = 1'b1; start_i = 1'b0; spike_i = 1'b0; count_i = '0;
    tick_i = '0; pop_ready_i = 1'b0;
    step();
    step();
    check_all_zero("reset");
`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
    check("reset drop_cnt", 32'(drop_cnt_o), 32'd0);
`endif
    rst_i = 1'b0;

    // Basic ordering: 3, 17, 40 then drain
    do_start();
    check("start level", 32'(level_o), 32'd0);
    spike(8'd3);
    check("latency valid", 32'(pop_valid_o), 32'd1);
    check("latency addr", 32'(pop_addr_o), 32'd3);
    spike(8'd17);
    spike(8'd40);
    check("three level", 32'(level_o), 32'd3);
    step();
    check("hold addr", 32'(pop_addr_o), 32'd3);
    pop_ready_i = 1'b1;
    step();
    check("pop2 addr", 32'(pop_addr_o), 32'd17);
    check("pop2 level", 32'(level_o), 32'd2);
    step();
    check("pop3 addr", 32'(pop_addr_o), 32'd40);
    step();
    check("drained valid", 32'(pop_valid_o), 32'd0);
    check("drained level", 32'(level_o), 32'd0);
    pop_ready_i = 1'b0;

    // Overflow: 0..9 into an 8-deep FIFO
    do_start();
    for (int i = 0; i < 10; i++) spike(8'(i));
    check("full level", 32'(level_o), 32'd8);
    check("full overflow", 32'(overflow_o), 32'd1);
    check("full head", 32'(pop_addr_o), 32'd0);
`ifdef SPIKE_PUSHBACK_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt_o), 32'd2);
`endif

    // Full with simultaneous push and pop
    pop_ready_i = 1'b1;
    spike(8'd100);
    pop_ready_i = 1'b0;
    check("fullpp level", 32'(level_o), 32'd8);
    check("fullpp overflow", 32'(overflow_o), 32'd1);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'd100);
    pop_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(pop_addr_o), 32'(exp_q[i]));
      step();
    end
    pop_ready_i = 1'b0;
    check("drain empty", 32'(pop_valid_o), 32'd0);

    // Start alongside a spike: the spike is discarded, flags cleared
    spike_i = 1'b1; count_i = 8'd5;
    do_start();
    spike_i = 1'b0;
    check("start spike level", 32'(level_o), 32'd0);
    check("start clr overflow", 32'(overflow_o), 32'd0);

    // Class spike ends inference
    spike(8'd250);
    check("win done", 32'(done_o), 32'd1);
    check("win valid", 32'(winner_valid_o), 32'd1);
    check("win addr", 32'(winner_addr_o), 32'd250);
    check("win timeout", 32'(timeout_o), 32'd0);
    spike(8'd12);
    check("done ignore level", 32'(level_o), 32'd1);
    check("done head", 32'(pop_addr_o), 32'd250);

    // Class spike and timeout together: spike wins
    do_start();
    check("restart done", 32'(done_o), 32'd0);
    tick_i = 8'd1;
    spike(8'd248);
    tick_i = 8'd0;
    check("tie winner", 32'(winner_valid_o), 32'd1);
    check("tie addr", 32'(winner_addr_o), 32'd248);
    check("tie timeout", 32'(timeout_o), 32'd0);

    // Timeout without class spike
    do_start();
    step();
    check("no timeout yet", 32'(done_o), 32'd0);
    tick_i = 8'd1;
    step();
    tick_i = 8'd0;
    check("to timeout", 32'(timeout_o), 32'd1);
    check("to winner", 32'(winner_valid_o), 32'd0);
    check("to done", 32'(done_o), 32'd1);

    // Asynchronous reset mid-run
    do_start();
    for (int i = 1; i <= 4; i++) spike(8'(i));
    check("pre-rst level", 32'(level_o), 32'd4);
    #2 rst_i = 1'b1;
    #1 check_all_zero("async rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    spike(8'd7);
    check("idle spike level", 32'(level_o), 32'd0);
    check("idle spike valid", 32'(pop_valid_o), 32'd0);
    check("idle done", 32'(done_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
